// File: rtl/fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_pkg
//
// Shared definitions for the instruction-fetch controller:
//   - bus widths (register bus and instruction address bus)
//   - the NOP word presented on inst_o whenever no live instruction is held
//   - the fetch FSM state encoding
//   - stall-vector layout (which bit holds the IF/ID stage)
//   - a helper that sizes the optional bus-wait timeout counter
//
// Optional feature macro: FETCH_TIMEOUT_EN (used by fetch_ctrl, not here).
// -----------------------------------------------------------------------------
package fetch_ctrl_pkg;

    localparam int REG_BUS_W       = 32;
    localparam int INST_ADDR_BUS_W = 32;

    typedef logic [REG_BUS_W-1:0]       reg_bus_t;
    typedef logic [INST_ADDR_BUS_W-1:0] inst_addr_t;

    // All-zero word decodes as a NOP (sll $0,$0,0).
    localparam reg_bus_t NOP_INST = 32'h0000_0000;

    // Stall vector from pipeline control; bit 1 holds the IF/ID register.
    localparam int STALL_W      = 6;
    localparam int STALL_IF_BIT = 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,   // no fetch in progress, bus idle
        S_REQ     = 2'd1,   // request on the bus for the current pc
        S_HOLD    = 2'd2,   // word captured, IF/ID stalled, bus idle
        S_DISCARD = 2'd3    // flushed request still outstanding; drop its data
    } fetch_state_t;

    // Timeout counter width: wide enough for the limit, never below 8 bits.
    function automatic int cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//
// Instruction bus between the fetch controller (master) and the instruction
// memory / bus fabric (slave).
//
//   ibus_req    master -> slave  request; held with ibus_addr until ibus_ack
//   ibus_addr   master -> slave  word address of the requested instruction
//   ibus_ack    slave  -> master one-cycle completion pulse
//   ibus_rdata  slave  -> master fetched word, valid in the ibus_ack cycle
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    import fetch_ctrl_pkg::*;

    logic       ibus_req;
    inst_addr_t ibus_addr;
    logic       ibus_ack;
    reg_bus_t   ibus_rdata;

    modport master (
        output ibus_req,
        output ibus_addr,
        input  ibus_ack,
        input  ibus_rdata
    );

    modport slave (
        input  ibus_req,
        input  ibus_addr,
        output ibus_ack,
        output ibus_rdata
    );

endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller sitting between the PC register and the IF/ID
// pipeline register. Issues one bus request at a time for the current pc,
// delivers the returned word to IF/ID, and asks the pipeline to stall while a
// request is outstanding.
//
// Parameters
//   TIMEOUT_CYCLES  bus-wait cycles before a fetch error (only with
//                   FETCH_TIMEOUT_EN defined)
//
// Ports
//   clk          clock, all state on posedge
//   rst          asynchronous, active-low reset
//   pc           fetch address from the PC register
//   ce           PC chip enable; 0 = stop fetching
//   stall[5:0]   pipeline stall vector; bit 1 holds IF/ID
//   flush        branch/exception flush; kills the in-flight fetch
//   ibus         instruction bus (fetch_ctrl_if.master)
//   inst_o       instruction to IF/ID (NOP when inst_valid is low)
//   inst_valid   inst_o carries a live instruction
//   stallreq_if  combinational stall request to pipeline control
//   fetch_err    one-cycle bus-timeout pulse
//
// Configuration
//   FETCH_TIMEOUT_EN  defined: a wait counter aborts a request after
//                     TIMEOUT_CYCLES cycles without ibus_ack and pulses
//                     fetch_err. Undefined: fetch_err is tied low and the
//                     controller waits indefinitely.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  inst_addr_t          pc,
    input  logic                ce,
    input  logic [STALL_W-1:0]  stall,
    input  logic                flush,
    fetch_ctrl_if.master        ibus,
    output reg_bus_t            inst_o,
    output logic                inst_valid,
    output logic                stallreq_if,
    output logic                fetch_err
);

    fetch_state_t state_reg;
    inst_addr_t   addr_reg;         // address frozen while discarding
    reg_bus_t     inst_reg;
    logic         inst_valid_reg;

    logic         if_hold;          // IF/ID is being held by the pipeline
    logic         timeout_hit;      // current wait has reached the limit

    assign if_hold = stall[STALL_IF_BIT];

    // Only the IF/ID hold bit matters to instruction fetch.
    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[STALL_W-1:STALL_IF_BIT+1],
                                 stall[STALL_IF_BIT-1:0]};

    // -------------------------------------------------------------------------
    // Bus outputs. In REQ the address follows pc directly: the PC register is
    // held by stallreq_if until the ack, and on the ack cycle the pipeline
    // advances so the next pc is presented on the very next cycle
    // (zero-wait back-to-back fetch). In DISCARD pc has already moved to the
    // flush target, so the old address comes from addr_reg.
    // -------------------------------------------------------------------------
    assign ibus.ibus_req  = (state_reg == S_REQ) || (state_reg == S_DISCARD);
    assign ibus.ibus_addr = (state_reg == S_REQ)     ? pc       :
                            (state_reg == S_DISCARD) ? addr_reg :
                                                       '0;

    // Stall while waiting for the bus; HOLD never requests a stall since the
    // pipeline itself is the one holding.
    assign stallreq_if = ((state_reg == S_REQ) && !ibus.ibus_ack) ||
                         (state_reg == S_DISCARD);

    assign inst_valid = inst_valid_reg;
    assign inst_o     = inst_valid_reg ? inst_reg : NOP_INST;

    // -------------------------------------------------------------------------
    // Optional bus-wait timeout
    // -------------------------------------------------------------------------
`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             fetch_err_reg;
    logic             waiting;
    logic             cnt_clear;

    assign waiting     = ((state_reg == S_REQ) || (state_reg == S_DISCARD)) &&
                         !ibus.ibus_ack;
    assign timeout_hit = waiting &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // A REQ -> DISCARD move starts a fresh wait, as does any completed or
    // aborted request; IDLE/HOLD keep the counter at zero.
    assign cnt_clear = !waiting || timeout_hit ||
                       ((state_reg == S_REQ) && flush);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_reg  <= '0;
            fetch_err_reg <= 1'b0;
        end else begin
            fetch_err_reg <= timeout_hit;
            if (cnt_clear) begin
                wait_cnt_reg <= '0;
            end else begin
                wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign fetch_err = fetch_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;

    // Parameter only matters when the timeout is built in.
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // -------------------------------------------------------------------------
    // Fetch FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            addr_reg       <= '0;
            inst_reg       <= NOP_INST;
            inst_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    // A stray ack here (e.g. from a request abandoned by
                    // reset) is ignored.
                    inst_valid_reg <= 1'b0;
                    if (ce) begin
                        state_reg <= S_REQ;
                    end
                end

                S_REQ: begin
                    if (!ce) begin
                        state_reg      <= S_IDLE;
                        inst_valid_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        // Abandon this attempt and re-issue for current pc.
                        state_reg      <= S_REQ;
                        inst_valid_reg <= 1'b0;
                    end else if (ibus.ibus_ack) begin
                        if (flush) begin
                            // Word belongs to the squashed path.
                            inst_valid_reg <= 1'b0;
                        end else begin
                            inst_reg       <= ibus.ibus_rdata;
                            inst_valid_reg <= 1'b1;
                            if (if_hold) begin
                                state_reg <= S_HOLD;
                            end
                        end
                    end else if (flush) begin
                        // Bus still owes us a word for the old address.
                        state_reg      <= S_DISCARD;
                        addr_reg       <= pc;
                        inst_valid_reg <= 1'b0;
                    end else begin
                        // Waiting: the previous word was consumed by IF/ID
                        // on the ack cycle, so present a bubble.
                        inst_valid_reg <= 1'b0;
                    end
                end

                S_HOLD: begin
                    if (!ce) begin
                        state_reg      <= S_IDLE;
                        inst_valid_reg <= 1'b0;
                    end else if (flush) begin
                        state_reg      <= S_REQ;
                        inst_valid_reg <= 1'b0;
                    end else if (!if_hold) begin
                        // IF/ID takes the held word on this edge; clearing
                        // valid keeps it from being delivered twice.
                        state_reg      <= S_REQ;
                        inst_valid_reg <= 1'b0;
                    end
                end

                S_DISCARD: begin
                    // Must see the ack (or give up) before doing anything
                    // else, even if ce drops meanwhile.
                    inst_valid_reg <= 1'b0;
                    if (ibus.ibus_ack || timeout_hit) begin
                        state_reg <= ce ? S_REQ : S_IDLE;
                    end
                end

                default: begin
                    state_reg      <= S_IDLE;
                    inst_valid_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule
